// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the banked register file and its clear sequencer.
package reg_file_pkg;

  // States of the clear-all sweep sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Register 0 is hard-wired to zero.
  localparam int ZERO_IDX = 0;

  // Default geometry, matching the emulator's 13x8 file with carry/status in r12.
  localparam int DEF_NUM_REGS  = 13;
  localparam int DEF_REG_WIDTH = 8;
  localparam int DEF_CAR_IDX   = 12;

endpackage

// File: rtl/reg_clr_seq.sv
// Clear-all sweep sequencer: walks r1..r(NUM_REGS-1), clearing one register per cycle,
// then pulses clr_done. An abort (restore) returns it to IDLE without clr_done.
module reg_clr_seq
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          accept,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);

  clr_state_t    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state, counter and handshake outputs; accept marks the cycle a sweep is taken.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    clr_done   = 1'b0;
    clr_en     = 1'b0;
    clr_idx    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          state_next = SWEEP;
          cnt_next   = FIRST_IDX;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          clr_en = 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + AW'(1);
          end
        end
      end
      DONE: begin
        clr_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/banked_reg_file.sv
// Parametrised general-purpose register file: r0 hard-wired zero, dedicated carry
// write port, optional write-to-read bypass, one-deep shadow bank and clear-all sweep.
module banked_reg_file
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int CAR_IDX   = DEF_CAR_IDX,
  parameter int BYPASS    = 1,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        rt_addr,
  input  logic [AW-1:0]        rs_addr,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 reg_write,
  input  logic                 reg_clear,
  input  logic [REG_WIDTH-1:0] rd_in,
  input  logic                 car_write,
  input  logic [REG_WIDTH-1:0] car_in,
  input  logic                 save_req,
  input  logic                 restore_req,
  input  logic                 clr_all_req,
  output logic [REG_WIDTH-1:0] rt_out,
  output logic [REG_WIDTH-1:0] rs_out,
  output logic [REG_WIDTH-1:0] rd_out,
  output logic                 busy,
  output logic                 clr_done,
  output logic                 shadow_valid
);

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] CAR_A   = AW'(CAR_IDX);
  localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_IDX);

  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
  logic [AW-1:0]        raddr  [3];
  logic [REG_WIDTH-1:0] rdata  [3];

  logic                 shadow_valid_reg;
  logic                 seq_busy, seq_done, seq_accept, clr_en;
  logic [AW-1:0]        clr_idx;
  logic                 restore_exec, save_exec, clr_start, writes_ok;
  logic                 reg_we, car_we;
  logic [REG_WIDTH-1:0] wdata;

  // Command arbitration: restore > save > clear-all > normal writes; busy blocks the lower three.
  assign restore_exec = restore_req && shadow_valid_reg;
  assign save_exec    = save_req && !restore_exec && !seq_busy;
  assign clr_start    = clr_all_req && !restore_exec && !save_req && !seq_busy;
  assign writes_ok    = !seq_busy && !restore_exec && !seq_accept;
  assign reg_we       = reg_write && writes_ok && (rd_addr != ZERO_A) &&
                        ({1'b0, rd_addr} < NREGS_W);
  assign car_we       = car_write && writes_ok;
  assign wdata        = reg_clear ? '0 : rd_in;

  reg_clr_seq #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (clr_start),
    .abort    (restore_exec),
    .accept   (seq_accept),
    .busy     (seq_busy),
    .clr_done (seq_done),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx)
  );

  assign regs_q[0] = '0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : gen_reg
    localparam logic [AW-1:0] IDX = AW'(gi);
    logic [REG_WIDTH-1:0] q_reg;
    logic [REG_WIDTH-1:0] shadow_reg;

    // Live register (restore > sweep clear > carry port > general port) and its shadow copy.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_reg      <= '0;
        shadow_reg <= '0;
      end else begin
        if (restore_exec) begin
          q_reg <= shadow_reg;
        end else if (clr_en && (clr_idx == IDX)) begin
          q_reg <= '0;
        end else if (car_we && (IDX == CAR_A)) begin
          q_reg <= car_in;
        end else if (reg_we && (rd_addr == IDX)) begin
          q_reg <= wdata;
        end
        if (save_exec) begin
          shadow_reg <= q_reg;
        end
      end
    end

    assign regs_q[gi] = q_reg;
  end

  assign raddr[0] = rt_addr;
  assign raddr[1] = rs_addr;
  assign raddr[2] = rd_addr;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_rport
    logic [REG_WIDTH-1:0] val;

    // Read mux: out-of-range and r0 read zero; carry write beats general write in the bypass.
    always_comb begin
      val = '0;
      if (({1'b0, raddr[gi]} < NREGS_W) && (raddr[gi] != ZERO_A)) begin
        val = regs_q[raddr[gi]];
        if (BYPASS != 0) begin
          if (car_we && (raddr[gi] == CAR_A)) begin
            val = car_in;
          end else if (reg_we && (raddr[gi] == rd_addr)) begin
            val = wdata;
          end
        end
      end
    end

    assign rdata[gi] = val;
  end

  // Snapshot-valid flag: set by an accepted save, cleared by the restore that consumes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_valid_reg <= 1'b0;
    end else if (restore_exec) begin
      shadow_valid_reg <= 1'b0;
    end else if (save_exec) begin
      shadow_valid_reg <= 1'b1;
    end
  end

  assign rt_out       = rdata[0];
  assign rs_out       = rdata[1];
  assign rd_out       = rdata[2];
  assign busy         = seq_busy;
  assign clr_done     = seq_done;
  assign shadow_valid = shadow_valid_reg;

endmodule
